// File: rtl/sultans_of_swing_pkg.sv
// rtl/sultans_of_swing_pkg.sv - shared width, word type and reset value for the sultans_of_swing slice
package sultans_of_swing_pkg;

    localparam int SOS_WIDTH_DEFAULT = 4;

    typedef logic [SOS_WIDTH_DEFAULT-1:0] sos_word_t;

    localparam sos_word_t SOS_RST_VAL = '0;

endpackage : sultans_of_swing_pkg

// File: rtl/sultans_of_swing_sos_reg.sv
// rtl/sultans_of_swing_sos_reg.sv - WIDTH-bit D-register with synchronous active-high reset to SOS_RST_VAL
module sos_reg
    import sultans_of_swing_pkg::*;
#(
    parameter int WIDTH = SOS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Capture d_i every edge; reset wins over data.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= WIDTH'(SOS_RST_VAL);
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : sos_reg

// File: rtl/sultans_of_swing.sv
// rtl/sultans_of_swing.sv - registered pass-through of A/B plus (A^B)&C; PARo parity output under SULTANS_OF_SWING_PARITY_EN
module sultans_of_swing
    import sultans_of_swing_pkg::*;
#(
    parameter int WIDTH = SOS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Ai,
    input  logic [WIDTH-1:0] Bi,
    input  logic [WIDTH-1:0] Ci,
    output logic [WIDTH-1:0] Ao,
    output logic [WIDTH-1:0] Bo,
`ifdef SULTANS_OF_SWING_PARITY_EN
    output logic [WIDTH-1:0] ANDo,
    output logic             PARo
`else
    output logic [WIDTH-1:0] ANDo
`endif
);

    logic [WIDTH-1:0] and_d;

    // Bitwise masked difference; no cross-bit terms.
    always_comb begin
        and_d = (Ai ^ Bi) & Ci;
    end

    sos_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (Ai),
        .q_o   (Ao)
    );

    sos_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (Bi),
        .q_o   (Bo)
    );

    sos_reg #(.WIDTH(WIDTH)) u_and_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (and_d),
        .q_o   (ANDo)
    );

`ifdef SULTANS_OF_SWING_PARITY_EN
    logic par_d;

    // Parity taken from the same-cycle term so it always tracks ^ANDo.
    always_comb begin
        par_d = ^and_d;
    end

    sos_reg #(.WIDTH(1)) u_par_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (par_d),
        .q_o   (PARo)
    );
`endif

endmodule : sultans_of_swing

// File: tb/tb_sultans_of_swing.sv
// tb/tb_sultans_of_swing.sv - scoreboard bench for sultans_of_swing, directed cases then random traffic
module tb_sultans_of_swing;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] andv;
        logic         par;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] Ai, Bi, Ci;
    logic [W-1:0] Ao, Bo, ANDo;
`ifdef SULTANS_OF_SWING_PARITY_EN
    logic         PARo;
`endif

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 0;

    sultans_of_swing #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .Ai    (Ai),
        .Bi    (Bi),
        .Ci    (Ci),
        .Ao    (Ao),
        .Bo    (Bo),
`ifdef SULTANS_OF_SWING_PARITY_EN
        .ANDo  (ANDo),
        .PARo  (PARo)
`else
        .ANDo  (ANDo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per-bit truth table, parity as count of set bits mod 2.
    function automatic exp_t model(input logic rst, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] c);
        exp_t e;
        int   ones;
        e = '0;
        ones = 0;
        if (!rst) begin
            e.a = a;
            e.b = b;
            for (int i = 0; i < W; i++) begin
                e.andv[i] = (a[i] != b[i]) && c[i];
                if (e.andv[i]) ones++;
            end
            e.par = (ones % 2) == 1;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, record what the next edge must produce.
    task automatic drive(input logic rst, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        reset = rst;
        Ai = a;
        Bi = b;
        Ci = c;
        exp_q.push_back(model(rst, a, b, c));
        @(negedge clk);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: after every edge the registered outputs must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("Ao", int'(Ao), int'(e.a));
                cmp("Bo", int'(Bo), int'(e.b));
                cmp("ANDo", int'(ANDo), int'(e.andv));
`ifdef SULTANS_OF_SWING_PARITY_EN
                cmp("PARo", int'(PARo), int'(e.par));
`endif
            end
        end
    end

    // Stimulus: directed cases first, then random operands with sparse resets.
    initial begin
        drive(1'b1, 4'b1111, 4'b1111, 4'b1111);
        drive(1'b0, 4'b0011, 4'b0110, 4'b0001);
        drive(1'b0, 4'b1011, 4'b0111, 4'b1100);
        drive(1'b0, 4'b1001, 4'b0111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0000, 4'b1111);
        drive(1'b0, 4'b1111, 4'b0000, 4'b0110);
        drive(1'b1, 4'b1010, 4'b0101, 4'b1111);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b1111, 4'b1010, 4'b1111);
        drive(1'b1, 4'b1111, 4'b1111, 4'b1111);
        drive(1'b0, 4'b0101, 4'b0011, 4'b1111);
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 15) == 0), W'($urandom), W'($urandom), W'($urandom));
        end
        stim_done = 1'b1;
    end

    // Finish once the scoreboard drains, bounded by a cycle budget.
    initial begin
        int cycles;
        cycles = 0;
        while (!(stim_done && exp_q.size() == 0) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (!(stim_done && exp_q.size() == 0)) begin
            failures++;
            $display("FAIL drain pending=%0d required=0 after %0d cycles", exp_q.size(), cycles);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sultans_of_swing
